readout_rx_integrator: RTL and testbench

Integrates the calibrated I/Q stream from the readout RX calibration unit over a programmable window. It then thresholds the integrated I value into a single-bit qubit-state decision. It sits directly downstream of the calibration stage, takes its `i_out`/`q_out`/`valid_out` as inputs, and hands per-shot results to the readout result buffer.

---
 rtl/readout_rx_integrator_pkg.sv | 10 +
 rtl/readout_rx_accumulator.sv | 19 +
 rtl/readout_rx_integrator.sv | 81 ++++++++
 tb/tb_readout_rx_integrator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/readout_rx_integrator_pkg.sv
// readout_rx_integrator_pkg: shared widths and FSM encoding for the readout RX integrator and result buffer
package readout_rx_integrator_pkg;
  localparam int IQ_WIDTH_DEF  = 16;
  localparam int LEN_WIDTH_DEF = 10;
  localparam int ACC_WIDTH_DEF = 26;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, ACCUM = ST_ACCUM, DONE = ST_DONE} state_t;
endpackage

// File: rtl/readout_rx_accumulator.sv
// readout_rx_accumulator: signed accumulator with synchronous clear and enable
module readout_rx_accumulator #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 26
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [ACC_WIDTH-1:0] acc
);
  logic signed [ACC_WIDTH-1:0] din_ext;
  assign din_ext = {{(ACC_WIDTH-IN_WIDTH){din[IN_WIDTH-1]}}, din};
  // clear wins over accumulate so a new window always starts from zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else acc <= clr ? '0 : en ? acc + din_ext : acc;
endmodule

// File: rtl/readout_rx_integrator.sv
// readout_rx_integrator: integrates calibrated I/Q over a window and thresholds I into a state bit
module readout_rx_integrator
  import readout_rx_integrator_pkg::*;
#(
  parameter int IQ_WIDTH  = IQ_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [LEN_WIDTH-1:0]        int_len,
  input  logic signed [ACC_WIDTH-1:0] threshold,
  input  logic signed [IQ_WIDTH-1:0]  i_in,
  input  logic signed [IQ_WIDTH-1:0]  q_in,
  input  logic                        valid_in,
  output logic signed [ACC_WIDTH-1:0] i_acc_out,
  output logic signed [ACC_WIDTH-1:0] q_acc_out,
  output logic                        state_out,
  output logic                        valid_out,
  output logic                        busy
);
  state_t state, state_nxt;
  logic [LEN_WIDTH-1:0] len_q, cnt;
  logic signed [ACC_WIDTH-1:0] thr_q, acc_i, acc_q;
  logic go, en, last;
  // a start is only taken in IDLE and not while the previous result is still being presented
  assign go   = state == IDLE && start && !valid_out;
  assign en   = state == ACCUM && valid_in && !abort;
  assign last = cnt == len_q - LEN_WIDTH'(1);
  assign busy = state == ACCUM;
  readout_rx_accumulator #(.IN_WIDTH(IQ_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_acc_i (
    .clk(clk), .rst_n(rst_n), .clr(go), .en(en), .din(i_in), .acc(acc_i)
  );
  readout_rx_accumulator #(.IN_WIDTH(IQ_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_acc_q (
    .clk(clk), .rst_n(rst_n), .clr(go), .en(en), .din(q_in), .acc(acc_q)
  );
  // next-state logic; abort beats a same-cycle final sample
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = go ? (int_len == '0 ? DONE : ACCUM) : IDLE;
      ACCUM:   state_nxt = abort ? IDLE : (valid_in && last) ? DONE : ACCUM;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // window parameters latched on start, sample counter advanced per accepted sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len_q <= '0;
      thr_q <= '0;
      cnt   <= '0;
    end else if (go) begin
      len_q <= int_len;
      thr_q <= threshold;
      cnt   <= '0;
    end else if (en) begin
      cnt <= cnt + LEN_WIDTH'(1);
    end
  // publish the window result on leaving DONE; outputs hold otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_out <= 1'b0;
      i_acc_out <= '0;
      q_acc_out <= '0;
      state_out <= 1'b0;
    end else begin
      valid_out <= state == DONE;
      if (state == DONE) begin
        i_acc_out <= acc_i;
        q_acc_out <= acc_q;
        state_out <= acc_i > thr_q;
      end
    end
endmodule

// File: tb/tb_readout_rx_integrator.sv
// tb_readout_rx_integrator: randomized self-checking bench with a sum-of-samples reference model
module tb_readout_rx_integrator;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, valid_in = 0;
  logic state_out, valid_out, busy;
  logic [9:0] int_len = '0;
  logic signed [25:0] threshold = '0, i_acc_out, q_acc_out;
  logic signed [15:0] i_in = '0, q_in = '0;
  int cyc = 0, n_pulse = 0, pulse_cyc = 0, n_chk = 0, n_pass = 0, final_edge = 0, base = 0;
  logic signed [25:0] cap_i = '0, cap_q = '0, exp_i, exp_q;
  logic cap_s = 0, exp_s;
  logic signed [15:0] si[64], sq[64];
  logic sv[64];

  readout_rx_integrator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .int_len(int_len),
    .threshold(threshold), .i_in(i_in), .q_in(q_in), .valid_in(valid_in),
    .i_acc_out(i_acc_out), .q_acc_out(q_acc_out), .state_out(state_out),
    .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (valid_out) begin
      n_pulse   <= n_pulse + 1;
      pulse_cyc <= cyc;
      cap_i     <= i_acc_out;
      cap_q     <= q_acc_out;
      cap_s     <= state_out;
    end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  // Starts a window and feeds si/sq/sv; the model sums the first len valid samples after start.
  // Entered and left at 1 time unit after a rising edge.
  task automatic drive_window(input int len, input logic signed [25:0] thr, input int n, input int dup, input int tail);
    longint s_i, s_q;
    int got;
    s_i = 0; s_q = 0; got = 0; base = n_pulse;
    start = 1; int_len = 10'(len); threshold = thr;
    valid_in = 1; i_in = 16'sh1234; q_in = -16'sh0100;
    @(posedge clk); #1;
    final_edge = cyc; start = 0;
    for (int k = 0; k < n; k++) begin
      i_in = si[k]; q_in = sq[k]; valid_in = sv[k];
      start = (k == dup);
      int_len = (k == dup) ? 10'd500 : 10'($urandom);
      threshold = 26'($urandom);
      if (sv[k] && got < len) begin
        got++; s_i += si[k]; s_q += sq[k];
        if (got == len) final_edge = cyc + 1;
      end
      @(posedge clk); #1;
    end
    start = 0; valid_in = 0;
    exp_i = 26'(s_i); exp_q = 26'(s_q); exp_s = s_i > longint'(thr);
    repeat (tail) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (i_acc_out !== 26'sd0) $display("FAIL reset_i got %0d want 0", i_acc_out); else n_pass++;
    n_chk++; if (q_acc_out !== 26'sd0) $display("FAIL reset_q got %0d want 0", q_acc_out); else n_pass++;
    n_chk++; if (state_out !== 1'b0) $display("FAIL reset_state got %b want 0", state_out); else n_pass++;
    n_chk++; if (valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_out); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    si[0] = 100; si[1] = -20; si[2] = 50; si[3] = 10;
    sq[0] = 1; sq[1] = 2; sq[2] = 3; sq[3] = 4;
    for (int k = 0; k < 4; k++) sv[k] = 1;
    drive_window(4, 26'sd0, 4, -1, 4);
    n_chk++; if (cap_i !== 26'sd140) $display("FAIL basic_i got %0d want 140", cap_i); else n_pass++;
    n_chk++; if (cap_q !== 26'sd10) $display("FAIL basic_q got %0d want 10", cap_q); else n_pass++;
    n_chk++; if (cap_s !== 1'b1) $display("FAIL basic_state got %b want 1", cap_s); else n_pass++;
    n_chk++; if (n_pulse - base !== 1) $display("FAIL basic_pulses got %0d want 1", n_pulse - base); else n_pass++;
    n_chk++; if (pulse_cyc !== final_edge + 1) $display("FAIL basic_latency got %0d want %0d", pulse_cyc, final_edge + 1); else n_pass++;
  endtask

  task automatic test_gapped;
    for (int k = 0; k < 5; k++) begin
      si[k] = -16'sd32768; sq[k] = 16'(k * 7 - 9); sv[k] = (k % 2 == 0);
    end
    drive_window(3, -26'sd5, 5, -1, 4);
    n_chk++; if (cap_i !== -26'sd98304) $display("FAIL gapped_i got %0d want -98304", cap_i); else n_pass++;
    n_chk++; if (cap_q !== exp_q) $display("FAIL gapped_q got %0d want %0d", cap_q, exp_q); else n_pass++;
    n_chk++; if (cap_s !== 1'b0) $display("FAIL gapped_state got %b want 0", cap_s); else n_pass++;
    n_chk++; if (n_pulse - base !== 1) $display("FAIL gapped_pulses got %0d want 1", n_pulse - base); else n_pass++;
  endtask

  task automatic test_zero_len;
    si[0] = 999; sq[0] = 999; sv[0] = 1;
    drive_window(0, -26'sd1, 1, -1, 4);
    n_chk++; if (cap_i !== 26'sd0) $display("FAIL zero_i got %0d want 0", cap_i); else n_pass++;
    n_chk++; if (cap_q !== 26'sd0) $display("FAIL zero_q got %0d want 0", cap_q); else n_pass++;
    n_chk++; if (cap_s !== 1'b1) $display("FAIL zero_state_neg got %b want 1", cap_s); else n_pass++;
    n_chk++; if (n_pulse - base !== 1) $display("FAIL zero_pulses got %0d want 1", n_pulse - base); else n_pass++;
    n_chk++; if (pulse_cyc !== final_edge + 1) $display("FAIL zero_latency got %0d want %0d", pulse_cyc, final_edge + 1); else n_pass++;
    drive_window(0, 26'sd0, 1, -1, 4);
    n_chk++; if (cap_s !== 1'b0) $display("FAIL zero_state_pos got %b want 0", cap_s); else n_pass++;
  endtask

  task automatic test_abort;
    si[0] = 77; sq[0] = -3; sv[0] = 1;
    drive_window(1, 26'sd0, 1, -1, 4);
    base = n_pulse;
    start = 1; int_len = 10'd8; threshold = '0;
    @(posedge clk); #1;
    start = 0;
    n_chk++; if (busy !== 1'b1) $display("FAIL abort_busy_on got %b want 1", busy); else n_pass++;
    for (int k = 0; k < 7; k++) begin
      valid_in = 1; i_in = 16'($urandom); q_in = 16'($urandom);
      @(posedge clk); #1;
    end
    abort = 1; valid_in = 1;
    @(posedge clk); #1;
    abort = 0;
    n_chk++; if (busy !== 1'b0) $display("FAIL abort_busy_off got %b want 0", busy); else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    valid_in = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (n_pulse - base !== 0) $display("FAIL abort_pulses got %0d want 0", n_pulse - base); else n_pass++;
    n_chk++; if (i_acc_out !== 26'sd77) $display("FAIL abort_hold_i got %0d want 77", i_acc_out); else n_pass++;
    n_chk++; if (q_acc_out !== -26'sd3) $display("FAIL abort_hold_q got %0d want -3", q_acc_out); else n_pass++;
    n_chk++; if (state_out !== 1'b1) $display("FAIL abort_hold_state got %b want 1", state_out); else n_pass++;
    for (int k = 0; k < 5; k++) begin si[k] = 16'($urandom); sq[k] = 16'($urandom); sv[k] = 1; end
    drive_window(5, 26'sd100, 5, -1, 4);
    n_chk++; if (cap_i !== exp_i) $display("FAIL abort_next_i got %0d want %0d", cap_i, exp_i); else n_pass++;
    n_chk++; if (n_pulse - base !== 1) $display("FAIL abort_next_pulses got %0d want 1", n_pulse - base); else n_pass++;
  endtask

  task automatic test_ignored_start;
    for (int k = 0; k < 4; k++) begin si[k] = 16'(k * 1000 + 7); sq[k] = 16'(-k); sv[k] = 1; end
    drive_window(2, 26'sd10, 4, 0, 4);
    n_chk++; if (cap_i !== 26'sd1014) $display("FAIL busy_start_i got %0d want 1014", cap_i); else n_pass++;
    n_chk++; if (n_pulse - base !== 1) $display("FAIL busy_start_pulses got %0d want 1", n_pulse - base); else n_pass++;
    drive_window(1, 26'sd0, 3, 2, 2);
    n_chk++; if (n_pulse - base !== 1) $display("FAIL vo_start_pulses got %0d want 1", n_pulse - base); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL vo_start_busy got %b want 0", busy); else n_pass++;
    for (int k = 0; k < 3; k++) begin si[k] = 16'(-500 * k); sq[k] = 16'(k); sv[k] = 1; end
    drive_window(3, 26'sd0, 3, -1, 2);
    for (int k = 0; k < 2; k++) begin si[k] = 16'(300 + k); sq[k] = 16'(5 * k); sv[k] = 1; end
    drive_window(2, 26'sd600, 2, -1, 4);
    n_chk++; if (cap_i !== 26'sd601) $display("FAIL b2b_i got %0d want 601", cap_i); else n_pass++;
    n_chk++; if (cap_s !== 1'b1) $display("FAIL b2b_state got %b want 1", cap_s); else n_pass++;
    n_chk++; if (n_pulse - base !== 1) $display("FAIL b2b_pulses got %0d want 1", n_pulse - base); else n_pass++;
  endtask

  task automatic test_random;
    int len, n, c;
    logic signed [25:0] thr;
    for (int w = 0; w < 25; w++) begin
      len = $urandom_range(0, 12);
      n = 3 * len + 2;
      c = 0;
      for (int k = 0; k < n; k++) begin
        si[k] = 16'($urandom); sq[k] = 16'($urandom); sv[k] = ($urandom_range(0, 3) != 0);
        c += int'(sv[k]);
      end
      for (int k = n - 1; k >= 0 && c < len; k--) if (!sv[k]) begin sv[k] = 1; c++; end
      thr = 26'(int'($urandom_range(0, 400000)) - 200000);
      drive_window(len, thr, n, -1, 4);
      n_chk++; if (cap_i !== exp_i) $display("FAIL rand_i w%0d got %0d want %0d", w, cap_i, exp_i); else n_pass++;
      n_chk++; if (cap_q !== exp_q) $display("FAIL rand_q w%0d got %0d want %0d", w, cap_q, exp_q); else n_pass++;
      n_chk++; if (cap_s !== exp_s) $display("FAIL rand_state w%0d got %b want %b", w, cap_s, exp_s); else n_pass++;
      n_chk++; if (n_pulse - base !== 1) $display("FAIL rand_pulses w%0d got %0d want 1", w, n_pulse - base); else n_pass++;
      n_chk++; if (pulse_cyc !== final_edge + 1) $display("FAIL rand_latency w%0d got %0d want %0d", w, pulse_cyc, final_edge + 1); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    si[0] = 1234; sq[0] = -55; sv[0] = 1;
    drive_window(1, 26'sd0, 1, -1, 4);
    n_chk++; if (i_acc_out !== 26'sd1234) $display("FAIL rmid_pre_i got %0d want 1234", i_acc_out); else n_pass++;
    base = n_pulse;
    start = 1; int_len = 10'd6;
    @(posedge clk); #1;
    start = 0;
    for (int k = 0; k < 2; k++) begin
      valid_in = 1; i_in = 16'sd100; q_in = 16'sd100;
      @(posedge clk); #1;
    end
    #2 rst_n = 0;
    #1;
    n_chk++; if (i_acc_out !== 26'sd0) $display("FAIL rmid_i got %0d want 0", i_acc_out); else n_pass++;
    n_chk++; if (q_acc_out !== 26'sd0) $display("FAIL rmid_q got %0d want 0", q_acc_out); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (4) @(posedge clk);
    #1;
    valid_in = 0;
    repeat (4) @(posedge clk);
    #1;
    n_chk++; if (n_pulse - base !== 0) $display("FAIL rmid_pulses got %0d want 0", n_pulse - base); else n_pass++;
    n_chk++; if (i_acc_out !== 26'sd0) $display("FAIL rmid_hold_i got %0d want 0", i_acc_out); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gapped;
    test_zero_len;
    test_abort;
    test_ignored_start;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
